// File: rtl/wisc_pkg.sv
// Shared WISC decode definitions: opcodes, immediate classes, FSM states and the
// packet handed from decode to execute.
package wisc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned IMM_W   = 16;

  localparam logic [REG_W-1:0] LINK_REG_DEF = 3'd7;

  localparam logic [OP_W-1:0] OP_HALT  = 5'b00000;
  localparam logic [OP_W-1:0] OP_NOP   = 5'b00001;
  localparam logic [OP_W-1:0] OP_SIIC  = 5'b00010;
  localparam logic [OP_W-1:0] OP_RTI   = 5'b00011;
  localparam logic [OP_W-1:0] OP_J     = 5'b00100;
  localparam logic [OP_W-1:0] OP_JR    = 5'b00101;
  localparam logic [OP_W-1:0] OP_JAL   = 5'b00110;
  localparam logic [OP_W-1:0] OP_JALR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ADDI  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SUBI  = 5'b01001;
  localparam logic [OP_W-1:0] OP_XORI  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ANDNI = 5'b01011;
  localparam logic [OP_W-1:0] OP_BEQZ  = 5'b01100;
  localparam logic [OP_W-1:0] OP_BNEZ  = 5'b01101;
  localparam logic [OP_W-1:0] OP_BLTZ  = 5'b01110;
  localparam logic [OP_W-1:0] OP_BGEZ  = 5'b01111;
  localparam logic [OP_W-1:0] OP_ST    = 5'b10000;
  localparam logic [OP_W-1:0] OP_LD    = 5'b10001;
  localparam logic [OP_W-1:0] OP_SLBI  = 5'b10010;
  localparam logic [OP_W-1:0] OP_STU   = 5'b10011;
  localparam logic [OP_W-1:0] OP_ROLI  = 5'b10100;
  localparam logic [OP_W-1:0] OP_SLLI  = 5'b10101;
  localparam logic [OP_W-1:0] OP_RORI  = 5'b10110;
  localparam logic [OP_W-1:0] OP_SRLI  = 5'b10111;
  localparam logic [OP_W-1:0] OP_LBI   = 5'b11000;
  localparam logic [OP_W-1:0] OP_BTR   = 5'b11001;
  localparam logic [OP_W-1:0] OP_SHIFT = 5'b11010;
  localparam logic [OP_W-1:0] OP_ARITH = 5'b11011;
  localparam logic [OP_W-1:0] OP_SEQ   = 5'b11100;
  localparam logic [OP_W-1:0] OP_SLT   = 5'b11101;
  localparam logic [OP_W-1:0] OP_SLE   = 5'b11110;
  localparam logic [OP_W-1:0] OP_SCO   = 5'b11111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_S5,
    IMM_Z5,
    IMM_S8,
    IMM_Z8,
    IMM_S11
  } imm_class_e;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]  alu_op;
    logic [1:0]       last2;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             halt;
    logic             err;
  } ex_pkt_t;

endpackage

// File: rtl/id_imm_ext.sv
// Immediate extender: selects and sign/zero-extends the immediate field of an
// instruction according to its immediate class.
module id_imm_ext
  import wisc_pkg::*;
(
  input  logic [10:0]      field,
  input  imm_class_e       imm_class,
  output logic [IMM_W-1:0] imm_c
);

  always_comb begin
    imm_c = '0;
    case (imm_class)
      IMM_S5:  imm_c = {{11{field[4]}}, field[4:0]};
      IMM_Z5:  imm_c = {11'b0, field[4:0]};
      IMM_S8:  imm_c = {{8{field[7]}}, field[7:0]};
      IMM_Z8:  imm_c = {8'b0, field[7:0]};
      IMM_S11: imm_c = {{5{field[10]}}, field[10:0]};
      default: imm_c = '0;
    endcase
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// WISC decode/control stage: one registered decoded packet, halt FSM, sticky error.
// Define WISC_SIIC_RTI_EN to make SIIC/RTI legal jump-class instructions.
module id_ctrl_stage
  import wisc_pkg::*;
#(
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [REG_W-1:0]  LINK_REG = LINK_REG_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               if_ready,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [OP_W-1:0]    ex_aluOp,
  output logic [1:0]         ex_last2Bits,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic [IMM_W-1:0]   ex_imm,
  output logic               ex_regWrite,
  output logic               ex_memRead,
  output logic               ex_memWrite,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_halt,
  output logic               ex_err,
  output logic               halted,
  output logic               err
);

  state_e           state, state_next;
  ex_pkt_t          dec, pkt_d, pkt;
  imm_class_e       imm_class;
  logic [IMM_W-1:0] imm_c;
  logic [OP_W-1:0]  op;
  logic             accept;

  assign op = if_instr[15:11];

  // Opcode decode: register specifiers, immediate class and control strobes.
  always_comb begin
    dec        = '0;
    imm_class  = IMM_NONE;
    dec.alu_op = op;
    dec.last2  = if_instr[1:0];
    dec.rs     = if_instr[10:8];
    dec.rt     = if_instr[7:5];
    case (op)
      OP_HALT: dec.halt = 1'b1;
      OP_NOP:  ;
`ifdef WISC_SIIC_RTI_EN
      OP_SIIC: begin
        dec.jump      = 1'b1;
        dec.rd        = LINK_REG;
        dec.reg_write = 1'b1;
      end
      OP_RTI:  dec.jump = 1'b1;
`else
      OP_SIIC, OP_RTI: dec.err = 1'b1;
`endif
      OP_J: begin
        dec.jump  = 1'b1;
        imm_class = IMM_S11;
      end
      OP_JR: begin
        dec.jump  = 1'b1;
        imm_class = IMM_S8;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.rd        = LINK_REG;
        dec.reg_write = 1'b1;
        imm_class     = IMM_S11;
      end
      OP_JALR: begin
        dec.jump      = 1'b1;
        dec.rd        = LINK_REG;
        dec.reg_write = 1'b1;
        imm_class     = IMM_S8;
      end
      OP_ADDI, OP_SUBI: begin
        dec.rd        = if_instr[7:5];
        dec.reg_write = 1'b1;
        imm_class     = IMM_S5;
      end
      OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        dec.rd        = if_instr[7:5];
        dec.reg_write = 1'b1;
        imm_class     = IMM_Z5;
      end
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
        dec.branch = 1'b1;
        imm_class  = IMM_S8;
      end
      OP_ST: begin
        dec.rd        = if_instr[7:5];
        dec.mem_write = 1'b1;
        imm_class     = IMM_S5;
      end
      OP_LD: begin
        dec.rd        = if_instr[7:5];
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        imm_class     = IMM_S5;
      end
      OP_STU: begin
        dec.rd        = if_instr[7:5];
        dec.mem_write = 1'b1;
        dec.reg_write = 1'b1;
        imm_class     = IMM_S5;
      end
      OP_SLBI: begin
        dec.rd        = if_instr[10:8];
        dec.reg_write = 1'b1;
        imm_class     = IMM_Z8;
      end
      OP_LBI: begin
        dec.rd        = if_instr[10:8];
        dec.reg_write = 1'b1;
        imm_class     = IMM_S8;
      end
      OP_BTR, OP_SHIFT, OP_ARITH, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
        dec.rd        = if_instr[4:2];
        dec.reg_write = 1'b1;
      end
      default: ;
    endcase
    if (dec.err) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
    end
  end

  id_imm_ext u_imm_ext (
    .field     (if_instr[10:0]),
    .imm_class (imm_class),
    .imm_c     (imm_c)
  );

  always_comb begin
    pkt_d     = dec;
    pkt_d.imm = imm_c;
  end

  // Halt FSM next-state plus the fetch handshake it gates.
  always_comb begin
    state_next = state;
    if_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_RUN: begin
        if_ready = !rst && !flush && (!ex_valid || ex_ready);
        accept   = if_valid && if_ready;
        if (accept && dec.halt) state_next = ST_HALTED;
      end
      ST_HALTED: begin
        // Squashing the still-pending HALT undoes it; once consumed, halt is final.
        if (flush && ex_valid && pkt.halt) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Output packet register; flush outranks both accept and consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      pkt      <= '0;
      err      <= 1'b0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid <= 1'b1;
        pkt      <= pkt_d;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
      if (accept && dec.err) err <= 1'b1;
    end
  end

  assign halted       = (state == ST_HALTED);
  assign ex_aluOp     = pkt.alu_op;
  assign ex_last2Bits = pkt.last2;
  assign ex_rs        = pkt.rs;
  assign ex_rt        = pkt.rt;
  assign ex_rd        = pkt.rd;
  assign ex_imm       = pkt.imm;
  assign ex_regWrite  = pkt.reg_write;
  assign ex_memRead   = pkt.mem_read;
  assign ex_memWrite  = pkt.mem_write;
  assign ex_branch    = pkt.branch;
  assign ex_jump      = pkt.jump;
  assign ex_halt      = pkt.halt;
  assign ex_err       = pkt.err;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Scoreboard bench for id_ctrl_stage: directed plan cases plus randomized traffic
// against a table-driven reference decoder and transaction-level handshake model.
module tb_id_ctrl_stage;

  typedef struct packed {
    logic [4:0]  op;
    logic [1:0]  l2;
    logic [2:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        rw, mr, mw, br, jp, hl, er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        ex_valid;
  logic [4:0]  ex_aluOp;
  logic [1:0]  ex_last2Bits;
  logic [2:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_imm;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_branch, ex_jump, ex_halt, ex_err;
  logic        halted, err;
  exp_t        act;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bit   valid_m, halted_m, err_m, vhalt_m, check_en, mon_prev;

`ifdef WISC_SIIC_RTI_EN
  localparam bit SIIC_LEGAL = 1'b1;
`else
  localparam bit SIIC_LEGAL = 1'b0;
`endif

  id_ctrl_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_aluOp(ex_aluOp),
    .ex_last2Bits(ex_last2Bits), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_halt(ex_halt), .ex_err(ex_err),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  assign act = {ex_aluOp, ex_last2Bits, ex_rs, ex_rt, ex_rd, ex_imm, ex_regWrite,
                ex_memRead, ex_memWrite, ex_branch, ex_jump, ex_halt, ex_err};

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decoder: opcode number ranges and arithmetic field extension.
  function automatic exp_t ref_model(logic [15:0] ins);
    exp_t e;
    int   op, w, v;
    bit   sgn;
    op    = int'(ins[15:11]);
    e     = '0;
    e.op  = ins[15:11];
    e.l2  = ins[1:0];
    e.rs  = ins[10:8];
    e.rt  = ins[7:5];
    w     = 0;
    sgn   = 1'b0;
    if (op inside {8, 9, 16, 17, 19})                 begin w = 5;  sgn = 1'b1; end
    else if (op inside {10, 11, [20:23]})             begin w = 5;  sgn = 1'b0; end
    else if (op inside {5, 7, [12:15], 24})           begin w = 8;  sgn = 1'b1; end
    else if (op == 18)                                begin w = 8;  sgn = 1'b0; end
    else if (op == 4 || op == 6)                      begin w = 11; sgn = 1'b1; end
    if (w > 0) begin
      v = int'(ins) % (1 << w);
      if (sgn && v >= (1 << (w - 1))) v = v - (1 << w);
      e.imm = 16'(v);
    end
    if (op inside {[25:31]})                     e.rd = ins[4:2];
    else if (op inside {[8:11], [16:17], [19:23]}) e.rd = ins[7:5];
    else if (op == 18 || op == 24)               e.rd = ins[10:8];
    else if (op == 6 || op == 7)                 e.rd = 3'd7;
    e.rw = op inside {6, 7, [8:11], [17:31]};
    e.mr = (op == 17);
    e.mw = (op == 16 || op == 19);
    e.br = op inside {[12:15]};
    e.jp = op inside {[4:7]};
    e.hl = (op == 0);
    if (op == 2 || op == 3) begin
      if (SIIC_LEGAL) begin
        e.jp = 1'b1;
        if (op == 2) begin
          e.rd = 3'd7;
          e.rw = 1'b1;
        end
      end else begin
        e.er = 1'b1;
      end
    end
    return e;
  endfunction

  // One clock of stimulus plus the transaction-level handshake/halt model.
  task automatic cyc(bit v, logic [15:0] ins, bit rdy, bit fl, bit r);
    exp_t e;
    bit   ready_m, acc;
    @(negedge clk);
    #1;
    if_valid = v;
    if_instr = ins;
    ex_ready = rdy;
    flush    = fl;
    rst      = r;
    #1;
    if (check_en) begin
      chk("ex_valid", 64'(ex_valid), 64'(valid_m));
      chk("halted", 64'(halted), 64'(halted_m));
      chk("err", 64'(err), 64'(err_m));
    end
    ready_m = !r && !halted_m && !fl && (!valid_m || rdy);
    chk("if_ready", 64'(if_ready), 64'(ready_m));
    acc = v && ready_m;
    e   = ref_model(ins);
    if (acc) sb_q.push_back(e);
    if (r) begin
      valid_m  = 1'b0;
      halted_m = 1'b0;
      err_m    = 1'b0;
      vhalt_m  = 1'b0;
      check_en = 1'b1;
    end else if (fl) begin
      if (halted_m && valid_m && vhalt_m) halted_m = 1'b0;
      valid_m = 1'b0;
    end else if (acc) begin
      valid_m = 1'b1;
      vhalt_m = e.hl;
      if (e.hl) halted_m = 1'b1;
      if (e.er) err_m = 1'b1;
    end else if (rdy) begin
      valid_m = 1'b0;
    end
  endtask

  // Monitor: retire the previously shown packet when consumed or squashed, then
  // compare whatever the DUT presents now against the scoreboard head.
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        mon_prev = 1'b0;
      end else begin
        if (mon_prev && (ex_ready || flush) && sb_q.size() > 0) void'(sb_q.pop_front());
        if (ex_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pkt_unexpected got %0h exp none at %0t", act, $time);
          end else begin
            chk("pkt", 64'(act), 64'(sb_q[0]));
          end
        end
        mon_prev = (ex_valid === 1'b1);
      end
    end
  end

  initial begin
    logic [15:0] rins;
    for (int i = 0; i < 3; i++) cyc(0, 16'h0000, 1, 0, 1);
    cyc(0, 16'h0000, 1, 0, 0);
    chk("reset_pkt", 64'(act), 64'h0);

    // ADDI r2,r1,-3 then ADD r3,r1,r2 at full throughput
    cyc(1, 16'h415D, 1, 0, 0);
    cyc(1, 16'hD94C, 1, 0, 0);
    chk("addi_imm", 64'(ex_imm), 64'hFFFD);
    chk("addi_rd", 64'(ex_rd), 64'd2);
    chk("addi_rs", 64'(ex_rs), 64'd1);
    chk("addi_op", 64'(ex_aluOp), 64'b01000);
    chk("addi_rw", 64'(ex_regWrite), 64'd1);
    cyc(0, 16'h0000, 1, 0, 0);
    chk("add_op", 64'(ex_aluOp), 64'b11011);
    chk("add_rd", 64'(ex_rd), 64'd3);
    chk("add_rt", 64'(ex_rt), 64'd2);
    chk("add_l2", 64'(ex_last2Bits), 64'd0);
    cyc(0, 16'h0000, 1, 0, 0);

    // Back-to-back with a two-cycle execute stall
    cyc(1, 16'h415D, 0, 0, 0);
    cyc(1, 16'hD94C, 0, 0, 0);
    cyc(1, 16'hD94C, 0, 0, 0);
    cyc(1, 16'hD94C, 1, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0);
    chk("stall_second_rd", 64'(ex_rd), 64'd3);
    cyc(0, 16'h0000, 1, 0, 0);

    // JAL -1
    cyc(1, 16'h37FF, 1, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0);
    chk("jal_imm", 64'(ex_imm), 64'hFFFF);
    chk("jal_rd", 64'(ex_rd), 64'd7);
    chk("jal_jump", 64'(ex_jump), 64'd1);
    chk("jal_rw", 64'(ex_regWrite), 64'd1);
    cyc(0, 16'h0000, 1, 0, 0);

    // HALT held unconsumed, then squashed back to RUN
    cyc(1, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 16'h415D, 0, 0, 0);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_pkt", 64'(ex_halt), 64'd1);
    cyc(0, 16'h0000, 0, 1, 0);
    cyc(1, 16'h415D, 1, 0, 0);
    chk("halt_undone", 64'(halted), 64'd0);
    cyc(0, 16'h0000, 1, 0, 0);

    // HALT consumed: later flush cannot revive, only rst
    cyc(1, 16'h0000, 1, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0);
    cyc(0, 16'h0000, 1, 1, 0);
    cyc(1, 16'h415D, 1, 0, 0);
    chk("halt_terminal", 64'(halted), 64'd1);
    cyc(1, 16'h415D, 1, 0, 1);
    cyc(0, 16'h0000, 1, 0, 0);
    chk("halt_rst", 64'(halted), 64'd0);

    // SIIC opcode: illegal unless the optional feature is built in
    cyc(1, 16'h1000, 1, 0, 0);
    cyc(1, 16'h415D, 1, 0, 0);
    chk("siic_err", 64'(ex_err), 64'(!SIIC_LEGAL));
    chk("siic_rw", 64'(ex_regWrite), 64'(SIIC_LEGAL));
    chk("siic_jump", 64'(ex_jump), 64'(SIIC_LEGAL));
    cyc(0, 16'h0000, 1, 0, 0);
    chk("err_sticky", 64'(err), 64'(!SIIC_LEGAL));

    // rst during a stall drops both the held packet and the offered input
    cyc(1, 16'h415D, 0, 0, 0);
    cyc(1, 16'hD94C, 0, 0, 0);
    cyc(1, 16'hD94C, 0, 0, 1);
    cyc(0, 16'h0000, 1, 0, 0);
    chk("rst_stall_pkt", 64'(act), 64'h0);

    // Flush with execute stalled
    cyc(1, 16'h415D, 0, 0, 0);
    cyc(1, 16'hD94C, 0, 1, 0);
    cyc(0, 16'h0000, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rins = 16'($urandom);
      if (rins[15:11] == 5'd0 && $urandom_range(0, 3) != 0) rins[15:11] = 5'd1;
      cyc($urandom_range(0, 3) != 0, rins, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    for (int i = 0; i < 6; i++) cyc(0, 16'h0000, 1, 0, 0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
